fifo_frame_ctrl: RTL

FIFO_FRAME_CTRL -- requirements
Module: fifo_frame_ctrl

---
 rtl/fifo_frame_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fifo_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_frame_ctrl
//  Brief    : Frame controller that fills an external FIFO with one frame of
//             pixels, then drains it to a sink through a 2-entry skid buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_frame_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int FRAME_PIXELS = 65536,
    parameter int CNT_W        = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  fifo_en,
    output logic                  fifo_push_pop,
    output logic [DATA_WIDTH-1:0] fifo_din,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0]       c_ST_IDLE  = 2'd0;
    localparam logic [1:0]       c_ST_FILL  = 2'd1;
    localparam logic [1:0]       c_ST_DRAIN = 2'd2;
    localparam logic [CNT_W-1:0] c_FRAME    = CNT_W'(FRAME_PIXELS);
    localparam logic [CNT_W-1:0] c_LAST     = CNT_W'(FRAME_PIXELS - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [CNT_W-1:0]      r_fill_cnt;
    logic [CNT_W-1:0]      r_pop_cnt;
    logic [CNT_W-1:0]      r_out_cnt;
    logic                  r_inflight;
    logic                  r_done;
    logic [1:0]            r_occ;
    logic [1:0]            w_occ_nxt;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic [DATA_WIDTH-1:0] w_buf0_nxt;
    logic [DATA_WIDTH-1:0] w_buf1_nxt;

    logic       w_start_frame;
    logic       w_in_ready;
    logic       w_push;
    logic       w_pop;
    logic       w_out_valid;
    logic       w_take;
    logic       w_last_push;
    logic       w_last_take;
    logic [2:0] w_room;

    always_comb begin
        w_start_frame = (r_state == c_ST_IDLE) && start;
        w_out_valid   = (r_occ != 2'd0);
        w_take        = w_out_valid && out_ready;
        w_in_ready    = (r_state == c_ST_FILL) && (r_fill_cnt < c_FRAME) && !fifo_full;
        w_push        = w_in_ready && in_valid;
        // Projected buffer load once the pending capture lands and this cycle's take leaves.
        w_room        = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_take};
        w_pop         = (r_state == c_ST_DRAIN) && (r_pop_cnt < c_FRAME) && !fifo_empty
                        && (w_room < 3'd2);
        w_last_push   = w_push && (r_fill_cnt == c_LAST);
        w_last_take   = (r_state == c_ST_DRAIN) && w_take && (r_out_cnt == c_LAST);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (start)       w_state_nxt = c_ST_FILL;
            c_ST_FILL:  if (w_last_push) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: if (w_last_take) w_state_nxt = c_ST_IDLE;
            default:                     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Skid buffer update: r_buf0 is always the oldest entry.
    always_comb begin
        w_buf0_nxt = r_buf0;
        w_buf1_nxt = r_buf1;
        w_occ_nxt  = r_occ;
        case ({w_take, r_inflight})
            2'b01: begin
                if (r_occ == 2'd0) begin
                    w_buf0_nxt = fifo_dout;
                    w_occ_nxt  = 2'd1;
                end else begin
                    w_buf1_nxt = fifo_dout;
                    w_occ_nxt  = 2'd2;
                end
            end
            2'b10: begin
                w_buf0_nxt = r_buf1;
                w_occ_nxt  = r_occ - 2'd1;
            end
            2'b11: begin
                if (r_occ == 2'd1) begin
                    w_buf0_nxt = fifo_dout;
                end else begin
                    w_buf0_nxt = r_buf1;
                    w_buf1_nxt = fifo_dout;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_ST_IDLE;
            r_fill_cnt <= '0;
            r_pop_cnt  <= '0;
            r_out_cnt  <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
            r_occ      <= 2'd0;
            r_buf0     <= '0;
            r_buf1     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_pop;
            r_done     <= w_last_take;
            r_occ      <= w_occ_nxt;
            r_buf0     <= w_buf0_nxt;
            r_buf1     <= w_buf1_nxt;
            if (w_start_frame) begin
                r_fill_cnt <= '0;
                r_pop_cnt  <= '0;
                r_out_cnt  <= '0;
            end else begin
                if (w_push) r_fill_cnt <= r_fill_cnt + 1'b1;
                if (w_pop)  r_pop_cnt  <= r_pop_cnt + 1'b1;
                if (w_take && (r_state == c_ST_DRAIN)) r_out_cnt <= r_out_cnt + 1'b1;
            end
        end
    end

    assign in_ready      = w_in_ready;
    assign fifo_en       = w_push || w_pop;
    assign fifo_push_pop = !w_pop;
    assign fifo_din      = w_push ? in_data : '0;
    assign out_valid     = w_out_valid;
    assign out_data      = w_out_valid ? r_buf0 : '0;
    assign busy          = (r_state != c_ST_IDLE);
    assign done          = r_done;

endmodule
`default_nettype wire
